// File: rtl/apb4_bridge_n.sv
// Native valid/ready to APB4 bridge with N slave ports, unmapped-address
// error response and an optional wait-state timeout.
module apb4_bridge_n #(
  parameter int unsigned            NUM_SLV     = 8,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned            SLV_SEL_LSB = 12,
  parameter int unsigned            TIMEOUT     = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            mem_valid_i,
  input  logic [ADDR_WIDTH-1:0]           mem_addr_i,
  input  logic [DATA_WIDTH-1:0]           mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]         mem_wstrb_i,
  output logic                            mem_ready_o,
  output logic [DATA_WIDTH-1:0]           mem_rdata_o,
  output logic                            mem_err_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [2:0]                      pprot_o,
  output logic                            pwrite_o,
  output logic [DATA_WIDTH-1:0]           pwdata_o,
  output logic [DATA_WIDTH/8-1:0]         pstrb_o,
  output logic                            penable_o,
  output logic [NUM_SLV-1:0]              psel_o,
  input  logic [NUM_SLV*DATA_WIDTH-1:0]   prdata_i,
  input  logic [NUM_SLV-1:0]              pready_i,
  input  logic [NUM_SLV-1:0]              pslverr_i
);

  localparam int unsigned SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned HI_LSB = SLV_SEL_LSB + SEL_W;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_W'(0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state;
  logic [SEL_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt;

  logic [SEL_W-1:0]      req_idx;
  logic                  req_hit;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_ready;
  logic                  sel_err;

  // Decode: region tag must match and the index must name an existing slave
  assign req_idx   = mem_addr_i[SLV_SEL_LSB +: SEL_W];
  assign req_hit   = (mem_addr_i[ADDR_WIDTH-1:HI_LSB] == BASE_ADDR[ADDR_WIDTH-1:HI_LSB]) &&
                     (32'(req_idx) < NUM_SLV);

  // Only the latched slave's response lines are ever observed
  assign sel_rdata = prdata_i[32'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_ready = pready_i[idx_q];
  assign sel_err   = pslverr_i[idx_q];

  assign pprot_o   = 3'b000;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      idx_q       <= '0;
      cnt         <= '0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      mem_err_o   <= 1'b0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      penable_o   <= 1'b0;
      psel_o      <= '0;
    end else begin
      mem_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid_i) begin
            if (req_hit) begin
              paddr_o  <= mem_addr_i;
              pwdata_o <= mem_wdata_i;
              pstrb_o  <= mem_wstrb_i;
              pwrite_o <= |mem_wstrb_i;
              idx_q    <= req_idx;
              psel_o   <= NUM_SLV'(1) << req_idx;
              state    <= SETUP;
            end else begin
              mem_err_o   <= 1'b1;
              mem_rdata_o <= '0;
              mem_ready_o <= 1'b1;
              state       <= RESP;
            end
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout expiring in the same cycle
          if (sel_ready) begin
            mem_rdata_o <= pwrite_o ? '0 : sel_rdata;
            mem_err_o   <= sel_err;
            mem_ready_o <= 1'b1;
            psel_o      <= '0;
            penable_o   <= 1'b0;
            state       <= RESP;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            mem_rdata_o <= '0;
            mem_err_o   <= 1'b1;
            mem_ready_o <= 1'b1;
            psel_o      <= '0;
            penable_o   <= 1'b0;
            state       <= RESP;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
